// File: rtl/fft_bar_pkg.sv
// Shared definitions for the FFT-to-bar sequencer: FSM state encoding, bar
// height width, full-scale height and the converter-result clamp.
package fft_bar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_START,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int BAR_W = 7;
  localparam logic [BAR_W-1:0] BAR_MAX = 7'd96;

  function automatic logic [BAR_W-1:0] clamp_bar(input logic [BAR_W-1:0] v,
                                                 input logic [BAR_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/fft_bar_peak.sv
// Per-bar peak-hold store: the displayed value follows a rising result at once
// and otherwise falls by one step per frame.
module fft_bar_peak
  import fft_bar_pkg::*;
#(
  parameter int n_bars  = 32,
  parameter int bw_addr = 5
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               we,
  input  logic [bw_addr-1:0] addr,
  input  logic [BAR_W-1:0]   result,
  output logic [BAR_W-1:0]   peak
);

  logic [BAR_W-1:0] peak_reg [n_bars];
  logic [BAR_W-1:0] current;
  logic [BAR_W-1:0] decayed;

  // Read is combinational so the update fits inside the single write cycle.
  always_comb begin
    current = peak_reg[addr];
    decayed = (current == '0) ? '0 : current - 1'b1;
    peak    = (result >= decayed) ? result : decayed;
  end

  generate
    for (genvar gi = 0; gi < n_bars; gi++) begin : g_peak
      always_ff @(posedge clk) begin
        if (srst)
          peak_reg[gi] <= '0;
        else if (we && addr == bw_addr'(gi))
          peak_reg[gi] <= peak;
      end
    end
  endgenerate

endmodule

// File: rtl/fft_bar_sequencer.sv
// Walks the FFT bin RAM once per frame, runs each bin through the bar converter
// and writes the bar RAM. Optional peak hold: define FFT_BAR_PEAK_HOLD_EN.
module fft_bar_sequencer
  import fft_bar_pkg::*;
#(
  parameter int bw_input = 17,
  parameter int n_bars   = 32,
  parameter int bw_addr  = 5,
  parameter int max_wait = 63,
  parameter int bar_max  = int'(BAR_MAX)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                FrameStart,
  output logic                FrameBusy,
  output logic                FrameEnd,
  output logic                Error,
  output logic [bw_addr-1:0]  BinAddr,
  input  logic [bw_input-1:0] BinData,
  output logic                ConvStart,
  output logic [bw_input-1:0] ConvIn,
  input  logic [BAR_W-1:0]    ConvOut,
  input  logic                ConvEnd,
  output logic                BarWe,
  output logic [bw_addr-1:0]  BarAddr,
  output logic [BAR_W-1:0]    BarData
);

  localparam int TW = $clog2(max_wait + 1);
  localparam logic [BAR_W-1:0]   BAR_LIMIT  = BAR_W'(bar_max);
  localparam logic [TW-1:0]      TIMER_LAST = TW'(max_wait);
  localparam logic [bw_addr-1:0] INDEX_LAST = bw_addr'(n_bars - 1);

  state_t state_reg, state_next;
  logic [bw_addr-1:0]  index_reg;
  logic [TW-1:0]       timer_reg;
  logic [bw_input-1:0] conv_in_reg;
  logic [BAR_W-1:0]    result_reg;
  logic                error_reg;
  logic [BAR_W-1:0]    bar_value;
  logic                bar_we;

  always_ff @(posedge Clock) begin
    if (Reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (FrameStart) state_next = S_READ;
      S_READ:  state_next = S_LATCH;
      S_LATCH: state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT:  if (ConvEnd || timer_reg == TIMER_LAST) state_next = S_WRITE;
      S_WRITE: state_next = (index_reg == INDEX_LAST) ? S_DONE : S_READ;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      index_reg   <= '0;
      timer_reg   <= '0;
      conv_in_reg <= '0;
      result_reg  <= '0;
      error_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (FrameStart) begin
          index_reg <= '0;
          error_reg <= 1'b0;
        end
        S_LATCH: conv_in_reg <= BinData;
        S_START: timer_reg <= '0;
        S_WAIT: begin
          // A real End wins over a timeout landing in the same cycle.
          if (ConvEnd) begin
            result_reg <= clamp_bar(ConvOut, BAR_LIMIT);
          end else if (timer_reg == TIMER_LAST) begin
            result_reg <= '0;
            error_reg  <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_WRITE: if (index_reg != INDEX_LAST) index_reg <= index_reg + 1'b1;
        default: ;
      endcase
    end
  end

  assign bar_we = (state_reg == S_WRITE);

`ifdef FFT_BAR_PEAK_HOLD_EN
  fft_bar_peak #(
    .n_bars (n_bars),
    .bw_addr(bw_addr)
  ) u_peak (
    .clk   (Clock),
    .srst  (Reset),
    .we    (bar_we),
    .addr  (index_reg),
    .result(result_reg),
    .peak  (bar_value)
  );
`else
  assign bar_value = result_reg;
`endif

  always_comb begin
    FrameBusy = (state_reg != S_IDLE) && (state_reg != S_DONE);
    FrameEnd  = (state_reg == S_DONE);
    Error     = error_reg;
    BinAddr   = index_reg;
    ConvStart = (state_reg == S_START);
    ConvIn    = conv_in_reg;
    BarWe     = bar_we;
    BarAddr   = index_reg;
    BarData   = bar_we ? bar_value : '0;
  end

endmodule

// File: tb/tb_fft_bar_sequencer.sv
// Directed bench for fft_bar_sequencer: models the bin RAM and the converter,
// and checks every bar write against a queue of expected writes.
module tb_fft_bar_sequencer;

  localparam int N = 32;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        FrameStart = 1'b0;
  logic        FrameBusy, FrameEnd, Error;
  logic [4:0]  BinAddr;
  logic [16:0] BinData = '0;
  logic        ConvStart;
  logic [16:0] ConvIn;
  logic [6:0]  ConvOut = '0;
  logic        ConvEnd = 1'b0;
  logic        BarWe;
  logic [4:0]  BarAddr;
  logic [6:0]  BarData;

  fft_bar_sequencer dut (
    .Clock(Clock), .Reset(Reset), .FrameStart(FrameStart),
    .FrameBusy(FrameBusy), .FrameEnd(FrameEnd), .Error(Error),
    .BinAddr(BinAddr), .BinData(BinData),
    .ConvStart(ConvStart), .ConvIn(ConvIn), .ConvOut(ConvOut), .ConvEnd(ConvEnd),
    .BarWe(BarWe), .BarAddr(BarAddr), .BarData(BarData)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int addr;
    int data;
    int dly;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   lat[N];
  int   val[N];
  int   pk[N];
  bit   spurious_en = 1'b0;
  int   writes = 0;
  int   frame_ends = 0;
  int   start_cyc = 0;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge Clock) cyc++;

  // Bin RAM: data is the bin index, one cycle after the address.
  always @(posedge Clock) BinData <= 17'(BinAddr);

  // Converter: End L cycles after Start (never when L is 0).
  int cnt = 0;
  int cur_val = 0;
  bit prev_we = 1'b0;
  always begin
    @(posedge Clock);
    #1;
    ConvEnd = 1'b0;
    ConvOut = '0;
    if (Reset) begin
      cnt = 0;
      prev_we = 1'b0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ConvEnd = 1'b1;
          ConvOut = 7'(cur_val);
        end
      end else if (spurious_en && prev_we) begin
        ConvEnd = 1'b1;
        ConvOut = 7'd127;
      end
      if (ConvStart) begin
        cnt = lat[int'(ConvIn)];
        cur_val = val[int'(ConvIn)];
      end
      prev_we = BarWe;
    end
  end

  // Write monitor and scoreboard pop.
  always @(negedge Clock) begin
    if (ConvStart) start_cyc = cyc;
    if (FrameEnd) frame_ends++;
    if (BarWe) begin
      exp_t e;
      int   want;
      writes++;
      chk("write_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        want = e.data;
`ifdef FFT_BAR_PEAK_HOLD_EN
        begin
          int dec;
          dec = (pk[e.addr] == 0) ? 0 : pk[e.addr] - 1;
          want = (e.data >= dec) ? e.data : dec;
          pk[e.addr] = want;
        end
`endif
        chk($sformatf("bar_addr[%0d]", e.addr), int'(BarAddr), e.addr);
        chk($sformatf("bar_data[%0d]", e.addr), int'(BarData), want);
        chk($sformatf("bar_delay[%0d]", e.addr), cyc - start_cyc, e.dly);
      end
    end
  end

  task automatic push_frame();
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.addr = i;
      e.data = (lat[i] == 0) ? 0 : ((val[i] > 96) ? 96 : val[i]);
      e.dly  = (lat[i] == 0) ? 65 : lat[i] + 1;
      sb.push_back(e);
    end
  endtask

  task automatic default_config();
    for (int i = 0; i < N; i++) begin
      lat[i] = 5;
      val[i] = i * 3;
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < N; i++) pk[i] = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  int'(FrameBusy), 0);
    chk({tag, "_end"},   int'(FrameEnd),  0);
    chk({tag, "_error"}, int'(Error),     0);
    chk({tag, "_binaddr"}, int'(BinAddr), 0);
    chk({tag, "_start"}, int'(ConvStart), 0);
    chk({tag, "_convin"}, int'(ConvIn),   0);
    chk({tag, "_we"},    int'(BarWe),     0);
    chk({tag, "_baraddr"}, int'(BarAddr), 0);
    chk({tag, "_bardata"}, int'(BarData), 0);
  endtask

  // One full frame: start timing, completion, write count, sticky Error.
  task automatic run_frame(input string tag, input int exp_err, input bit pulse_busy);
    bit done;
    push_frame();
    writes = 0;
    frame_ends = 0;
    @(negedge Clock);
    FrameStart = 1'b1;
    @(negedge Clock);
    FrameStart = 1'b0;
    chk({tag, "_busy_c1"}, int'(FrameBusy), 1);
    chk({tag, "_err_clr"}, int'(Error), 0);
    chk({tag, "_binaddr_c1"}, int'(BinAddr), 0);
    @(negedge Clock);
    @(negedge Clock);
    chk({tag, "_convstart_c3"}, int'(ConvStart), 1);
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge Clock);
      FrameStart = pulse_busy && (i == 50 || i == 200);
      if (FrameEnd) done = 1'b1;
    end
    FrameStart = 1'b0;
    chk({tag, "_frame_end_seen"}, int'(done), 1);
    chk({tag, "_err_at_end"}, int'(Error), exp_err);
    repeat (20) @(negedge Clock);
    chk({tag, "_writes"}, writes, N);
    chk({tag, "_frame_ends"}, frame_ends, 1);
    chk({tag, "_busy_after"}, int'(FrameBusy), 0);
    chk({tag, "_err_sticky"}, int'(Error), exp_err);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    bit seen;
    default_config();
    for (int i = 0; i < N; i++) pk[i] = 0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    check_idle_outputs("reset");

    run_frame("ramp", 0, 1'b0);

    val[7] = 120;
    run_frame("clamp", 0, 1'b0);

    lat[4] = 0;
    run_frame("timeout", 1, 1'b0);
    lat[4] = 5;
    run_frame("after_timeout", 0, 1'b0);

    spurious_en = 1'b1;
    run_frame("spurious", 0, 1'b1);
    spurious_en = 1'b0;

    // Reset while waiting on bar 10's converter result.
    push_frame();
    writes = 0;
    @(negedge Clock);
    FrameStart = 1'b1;
    @(negedge Clock);
    FrameStart = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge Clock);
      if (ConvStart && ConvIn == 17'd10) seen = 1'b1;
    end
    chk("rst_bar10_start_seen", int'(seen), 1);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < N; i++) pk[i] = 0;
    check_idle_outputs("rst_wait");
    chk("rst_writes_before", writes, 10);
    sb.delete();
    repeat (20) @(negedge Clock);
    chk("rst_no_more_writes", writes, 10);
    chk("rst_stays_idle", int'(FrameBusy), 0);
    run_frame("after_reset", 0, 1'b0);

`ifdef FFT_BAR_PEAK_HOLD_EN
    do_reset();
    default_config();
    val[0] = 50;
    run_frame("peak_a", 0, 1'b0);
    val[0] = 0;
    run_frame("peak_b", 0, 1'b0);
    run_frame("peak_c", 0, 1'b0);
    chk("peak_decay_bar0", pk[0], 48);
    do_reset();
    val[0] = 50;
    run_frame("peak_d", 0, 1'b0);
    val[0] = 60;
    run_frame("peak_e", 0, 1'b0);
    chk("peak_rise_bar0", pk[0], 60);
`else
    do_reset();
    check_idle_outputs("final_reset");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
